// File: rtl/c432_irq_sched_pkg.sv
// Shared constants and enums for the c432 interrupt scheduler.
// Bus codes double as the gnt_bus_o encoding.
package c432_sched_pkg;

    localparam int NUM_CH  = 9;
    localparam int NUM_BUS = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        BUS_A = 2'd0,
        BUS_B = 2'd1,
        BUS_C = 2'd2
    } bus_e;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        GRANT
    } state_e;

endpackage

// File: rtl/c432_irq_sched_core.sv
// Combinational c432 priority decode: bus A over B over C, lowest channel wins.
// req packs bus A in [8:0], bus B in [17:9] and bus C in [26:18].
module c432_core
    import c432_sched_pkg::*;
(
    input  logic [NUM_BUS*NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0]         en,
    output logic                      hit_a,
    output logic                      hit_b,
    output logic                      hit_c,
    output logic [3:0]                chan
);

    logic [NUM_CH-1:0] va;
    logic [NUM_CH-1:0] vb;
    logic [NUM_CH-1:0] vc;
    logic [NUM_CH-1:0] win;

    assign va    = req[NUM_CH-1:0] & en;
    assign vb    = req[2*NUM_CH-1:NUM_CH] & en;
    assign vc    = req[3*NUM_CH-1:2*NUM_CH] & en;
    assign hit_a = |va;
    assign hit_b = |vb;
    assign hit_c = |vc;
    assign win   = hit_a ? va : (hit_b ? vb : vc);

    // Scan from the top so the lowest set channel is the last one written.
    always_comb begin
        chan = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (win[k]) chan = 4'(k);
        end
    end

endmodule

// File: rtl/c432_irq_sched.sv
// Interrupt scheduler: sticky pending regs, masked snapshot into the c432 core,
// fixed settle time, then one grant at a time over valid/ready.
module c432_irq_sched
    import c432_sched_pkg::*;
#(
    parameter int EVAL_CYCLES = 2,
    parameter int NUM_CH      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_a_i,
    input  logic [NUM_CH-1:0] req_b_i,
    input  logic [NUM_CH-1:0] req_c_i,
    input  logic              en_wr_i,
    input  logic [NUM_CH-1:0] en_data_i,
    output logic              gnt_valid_o,
    input  logic              gnt_ready_i,
    output logic [1:0]        gnt_bus_o,
    output logic [3:0]        gnt_chan_o,
    output logic              busy_o
);

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] pend_a, pend_b, pend_c;
    logic [NUM_CH-1:0] snap_a, snap_b, snap_c;
    logic [NUM_CH-1:0] snap_en;
    logic [NUM_CH-1:0] en_mask;
    logic [NUM_CH-1:0] clr_a, clr_b, clr_c;
    logic              any_pend;
    logic              accept;
    logic              hit_a, hit_b, hit_c;
    logic [3:0]        core_chan;
    logic [1:0]        core_bus;

    assign any_pend = |(pend_a & en_mask) | |(pend_b & en_mask) | |(pend_c & en_mask);
    assign accept   = (state == GRANT) && gnt_ready_i;

    // The mask is snapshotted with the requests so a mid-EVAL mask write cannot alter the result.
    c432_core u_core (
        .req   ({snap_c, snap_b, snap_a}),
        .en    (snap_en),
        .hit_a (hit_a),
        .hit_b (hit_b),
        .hit_c (hit_c),
        .chan  (core_chan)
    );

    assign core_bus = hit_a ? BUS_A : (hit_b ? BUS_B : BUS_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend) state_nxt = EVAL;
            EVAL:    if (cnt == '0) state_nxt = GRANT;
            GRANT:   if (gnt_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_a = '0;
        clr_b = '0;
        clr_c = '0;
        if (accept) begin
            case (gnt_bus_o)
                BUS_A:   clr_a[gnt_chan_o] = 1'b1;
                BUS_B:   clr_b[gnt_chan_o] = 1'b1;
                default: clr_c[gnt_chan_o] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a     <= '0;
            pend_b     <= '0;
            pend_c     <= '0;
            snap_a     <= '0;
            snap_b     <= '0;
            snap_c     <= '0;
            snap_en    <= '0;
            en_mask    <= '1;
            cnt        <= '0;
            gnt_bus_o  <= '0;
            gnt_chan_o <= '0;
        end else begin
            if (en_wr_i) en_mask <= en_data_i;
            // OR-ing requests after the clear lets a same-edge set win.
            pend_a <= (pend_a & ~clr_a) | req_a_i;
            pend_b <= (pend_b & ~clr_b) | req_b_i;
            pend_c <= (pend_c & ~clr_c) | req_c_i;
            if (state == IDLE && any_pend) begin
                snap_a  <= pend_a & en_mask;
                snap_b  <= pend_b & en_mask;
                snap_c  <= pend_c & en_mask;
                snap_en <= en_mask;
                cnt     <= CNT_W'(EVAL_CYCLES - 1);
            end
            if (state == EVAL) begin
                if (cnt == '0) begin
                    gnt_bus_o  <= core_bus;
                    gnt_chan_o <= core_chan;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign gnt_valid_o = (state == GRANT);
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_c432_irq_sched.sv
// Scoreboard bench for c432_irq_sched: expected grants are queued at stimulus
// time and checked as each grant is accepted.
module tb_c432_irq_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] req_a_i, req_b_i, req_c_i;
    logic       en_wr_i;
    logic [8:0] en_data_i;
    logic       gnt_valid_o;
    logic       gnt_ready_i;
    logic [1:0] gnt_bus_o;
    logic [3:0] gnt_chan_o;
    logic       busy_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int req_cyc;

    logic [5:0] sb[$];
    int         acc_cyc[$];

    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;
    logic [1:0] prev_bus;
    logic [3:0] prev_chan;

    c432_irq_sched #(.EVAL_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_c_i     (req_c_i),
        .en_wr_i     (en_wr_i),
        .en_data_i   (en_data_i),
        .gnt_valid_o (gnt_valid_o),
        .gnt_ready_i (gnt_ready_i),
        .gnt_bus_o   (gnt_bus_o),
        .gnt_chan_o  (gnt_chan_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!gnt_valid_o && n < maxc) begin
            step();
            n++;
        end
        check("valid_timeout", int'(gnt_valid_o), 1);
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        check("sb_drain", sb.size(), 0);
    endtask

    // Monitor: accepted grants are popped against the scoreboard; held grants must stay stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_acc   <= 1'b0;
        end else begin
            if (gnt_valid_o && prev_valid && !prev_acc) begin
                check("hold_bus", int'(gnt_bus_o), int'(prev_bus));
                check("hold_chan", int'(gnt_chan_o), int'(prev_chan));
            end
            if (gnt_valid_o && gnt_ready_i) begin
                check("grant_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    logic [5:0] e;
                    e = sb.pop_front();
                    check("gnt_bus", int'(gnt_bus_o), int'(e[5:4]));
                    check("gnt_chan", int'(gnt_chan_o), int'(e[3:0]));
                end
                acc_cyc.push_back(cyc + 1);
            end
            prev_valid <= gnt_valid_o;
            prev_acc   <= gnt_valid_o && gnt_ready_i;
            prev_bus   <= gnt_bus_o;
            prev_chan  <= gnt_chan_o;
        end
    end

    initial begin
        rst_n       = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_c_i     = '0;
        en_wr_i     = 1'b0;
        en_data_i   = '0;
        gnt_ready_i = 1'b0;
        #3;
        check("rst_valid", int'(gnt_valid_o), 0);
        check("rst_bus", int'(gnt_bus_o), 0);
        check("rst_chan", int'(gnt_chan_o), 0);
        check("rst_busy", int'(busy_o), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single request on C[7]: valid appears exactly three edges after capture.
        req_c_i[7] = 1'b1;
        sb.push_back({2'd2, 4'd7});
        step();
        req_c_i = '0;
        step();
        check("single_lat1", int'(gnt_valid_o), 0);
        step();
        check("single_lat2", int'(gnt_valid_o), 0);
        step();
        check("single_lat3", int'(gnt_valid_o), 1);
        gnt_ready_i = 1'b1;
        step();
        gnt_ready_i = 1'b0;
        step();
        step();
        check("single_idle", int'(busy_o), 0);
        wait_drain(5);

        // Priority A[5] > B[0] > C[0], ready held high, grants spaced 4 cycles.
        acc_cyc.delete();
        gnt_ready_i = 1'b1;
        req_a_i[5]  = 1'b1;
        req_b_i[0]  = 1'b1;
        req_c_i[0]  = 1'b1;
        sb.push_back({2'd0, 4'd5});
        sb.push_back({2'd1, 4'd0});
        sb.push_back({2'd2, 4'd0});
        step();
        req_cyc = cyc;
        req_a_i = '0;
        req_b_i = '0;
        req_c_i = '0;
        wait_drain(40);
        check("prio_count", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            check("prio_first_lat", acc_cyc[0] - req_cyc, 4);
            check("prio_space1", acc_cyc[1] - acc_cyc[0], 4);
            check("prio_space2", acc_cyc[2] - acc_cyc[1], 4);
        end
        step();
        check("prio_idle", int'(busy_o), 0);

        // Mask off channel 0: only B[3] is granted until the mask is restored.
        en_wr_i   = 1'b1;
        en_data_i = 9'h1FE;
        step();
        en_wr_i    = 1'b0;
        req_a_i[0] = 1'b1;
        req_b_i[3] = 1'b1;
        sb.push_back({2'd1, 4'd3});
        step();
        req_a_i = '0;
        req_b_i = '0;
        wait_drain(20);
        for (int i = 0; i < 6; i++) step();
        check("mask_blocked", int'(busy_o), 0);
        sb.push_back({2'd0, 4'd0});
        en_wr_i   = 1'b1;
        en_data_i = 9'h1FF;
        step();
        en_wr_i = 1'b0;
        wait_drain(20);
        step();
        gnt_ready_i = 1'b0;
        step();

        // Backpressure for 10 cycles, then a same-edge re-request that must win over the clear.
        req_a_i[2] = 1'b1;
        sb.push_back({2'd0, 4'd2});
        step();
        req_a_i = '0;
        wait_valid(10);
        for (int i = 0; i < 10; i++) step();
        check("bp_still_valid", int'(gnt_valid_o), 1);
        check("bp_bus", int'(gnt_bus_o), 0);
        check("bp_chan", int'(gnt_chan_o), 2);
        gnt_ready_i = 1'b1;
        req_a_i[2]  = 1'b1;
        sb.push_back({2'd0, 4'd2});
        step();
        gnt_ready_i = 1'b0;
        req_a_i     = '0;
        check("setwin_sb", sb.size(), 1);
        wait_valid(10);
        gnt_ready_i = 1'b1;
        step();
        gnt_ready_i = 1'b0;
        wait_drain(5);
        step();

        // Reset in the middle of a held grant for B[4].
        req_b_i[4] = 1'b1;
        step();
        req_b_i = '0;
        wait_valid(10);
        check("pre_rst_bus", int'(gnt_bus_o), 1);
        check("pre_rst_chan", int'(gnt_chan_o), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(gnt_valid_o), 0);
        check("midrst_bus", int'(gnt_bus_o), 0);
        check("midrst_chan", int'(gnt_chan_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("post_rst_valid", int'(gnt_valid_o), 0);
        check("post_rst_busy", int'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
